block_check_sched: RTL and testbench

Message-level scheduler that shares one begin/end block checker among `N` character-stream requesters. It grants one requester at a time in round-robin order and clears the checker before each message. It streams that requester's characters into the checker, appends a terminating space, and returns the checker verdict to the granted requester as a one-cycle response. It sits between the text-source front ends and the single checker instance.

---
 rtl/block_check_pkg.sv | 30 +++
 rtl/block_check_sched_arbiter.sv | 39 +++
 rtl/block_check_sched.sv | 152 +++++++++++++++
 tb/tb_block_check_sched.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_check_pkg.sv
// Shared state encoding, character constants and sizing helper for the
// block-check scheduler and its round-robin arbiter.
package block_check_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FLUSH  = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_TAIL   = 3'd3;
  localparam logic [2:0] ST_REPORT = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    FLUSH  = ST_FLUSH,
    STREAM = ST_STREAM,
    TAIL   = ST_TAIL,
    REPORT = ST_REPORT
  } state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/block_check_sched_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above the
// pointer, wrapping around, reported as one-hot grant plus index.
module rr_arbiter
  import block_check_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          hit_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  always_comb begin
    dbl   = {req_i, req_i} >> ptr_i;
    rot   = dbl[N-1:0];
    off   = '0;
    hit_o = 1'b0;
    // Scan downward so the lowest rotated offset (closest to the pointer) wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = IW'(k);
        hit_o = 1'b1;
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
    idx_o = sum[IW-1:0];
    gnt_o = hit_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/block_check_sched.sv
// Message-level scheduler sharing one begin/end block checker among N
// character-stream requesters, one whole message at a time.
module block_check_sched
  import block_check_pkg::*;
#(
  parameter  int N      = 2,
  parameter  int MAXLEN = 1024,
  localparam int IW     = clog2(N),
  localparam int LW     = clog2(MAXLEN + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   resp_valid,
  output logic           resp_ok,
  output logic           resp_err,
  output logic           busy,
  output logic [IW-1:0]  grant_idx,
  output logic           chk_reset,
  output logic [7:0]     chk_in,
  input  logic           chk_result
);

  state_e        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [N-1:0]  gnt_oh_q, gnt_oh_d;
  logic [LW-1:0] len_q, len_d;
  logic          err_q, err_d;

  logic [N-1:0]  arb_gnt;
  logic [IW-1:0] arb_idx;
  logic          arb_hit;

  logic [7:0]    sel_data;
  logic          sel_valid;
  logic          sel_last;
  logic          flush;

  function automatic logic [LW-1:0] len_sat_inc(input logic [LW-1:0] v);
    if (v == LW'(MAXLEN)) return v;
    return v + LW'(1);
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
    if (g == IW'(N - 1)) return '0;
    return g + IW'(1);
  endfunction

  rr_arbiter #(.N(N)) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .hit_o (arb_hit)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_oh_q[i]) sel_data = req_data[8*i +: 8];
    end
    sel_valid = |(req_valid & gnt_oh_q);
    sel_last  = |(req_last & gnt_oh_q);
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    gnt_oh_d   = gnt_oh_q;
    len_d      = len_q;
    err_d      = err_q;
    req_ready  = '0;
    resp_valid = '0;
    resp_ok    = 1'b0;
    resp_err   = 1'b0;
    chk_in     = ASCII_SPACE;
    flush      = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_hit) begin
          grant_d  = arb_idx;
          gnt_oh_d = arb_gnt;
          state_d  = FLUSH;
        end
      end
      FLUSH: begin
        flush   = 1'b1;
        len_d   = '0;
        err_d   = 1'b0;
        state_d = STREAM;
      end
      STREAM: begin
        req_ready = gnt_oh_q;
        chk_in    = sel_data;
        if (sel_valid) begin
          len_d = len_sat_inc(len_q);
          if (sel_last) begin
            state_d = TAIL;
          end else if (len_q == LW'(MAXLEN - 1)) begin
            err_d   = 1'b1;
            state_d = TAIL;
          end
        end else begin
          // The checker has already consumed this gap, so the message is lost.
          err_d   = 1'b1;
          state_d = TAIL;
        end
      end
      TAIL: begin
        state_d = REPORT;
      end
      REPORT: begin
        resp_valid = gnt_oh_q;
        resp_err   = err_q;
        resp_ok    = chk_result & ~err_q;
        rr_d       = next_ptr(grant_q);
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      grant_q  <= '0;
      gnt_oh_q <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      gnt_oh_q <= gnt_oh_d;
      len_q    <= len_d;
      err_q    <= err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign grant_idx = grant_q;
  assign chk_reset = reset | flush;

endmodule

// File: tb/tb_block_check_sched.sv
// Bench for block_check_sched: two instances (default MAXLEN and MAXLEN=8),
// each with a begin/end checker model, checked against a string-level reference.
module tb_block_check_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;
  int          n_err = 0;
  int          n_chk = 0;
  int          exp_rr = 0;
  int          first_acc [2][2];
  int          last_acc [2][2];

  logic [1:0]  a_v = '0, a_l = '0, b_v = '0, b_l = '0;
  logic [15:0] a_d = '0, b_d = '0;
  logic [1:0]  a_rdy, a_rv, b_rdy, b_rv;
  logic        a_ok, a_err, a_busy, a_gi, a_crst, a_cres;
  logic        b_ok, b_err, b_busy, b_gi, b_crst, b_cres;
  logic [7:0]  a_cin, b_cin;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  block_check_sched #(.N(2)) dut_a (
    .clk(clk), .reset(reset), .req_valid(a_v), .req_data(a_d), .req_last(a_l),
    .req_ready(a_rdy), .resp_valid(a_rv), .resp_ok(a_ok), .resp_err(a_err),
    .busy(a_busy), .grant_idx(a_gi), .chk_reset(a_crst), .chk_in(a_cin),
    .chk_result(a_cres));

  block_check_sched #(.N(2), .MAXLEN(8)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_v), .req_data(b_d), .req_last(b_l),
    .req_ready(b_rdy), .resp_valid(b_rv), .resp_ok(b_ok), .resp_err(b_err),
    .busy(b_busy), .grant_idx(b_gi), .chk_reset(b_crst), .chk_in(b_cin),
    .chk_result(b_cres));

  // Attached checker model: case-folded words, "begin" opens, "end" closes.
  typedef struct packed {
    logic [15:0] depth;
    logic        bad;
    logic [39:0] word;
    logic [2:0]  wlen;
  } chk_t;

  chk_t cs_a = '0, cs_b = '0;

  function automatic chk_t chk_step(input chk_t c, input logic [7:0] ch);
    chk_t n;
    logic [7:0] lc;
    n  = c;
    lc = ch;
    if (ch >= 8'h41 && ch <= 8'h5a) lc = ch + 8'h20;
    if (lc >= 8'h61 && lc <= 8'h7a) begin
      n.word = {c.word[31:0], lc};
      if (c.wlen < 3'd6) n.wlen = c.wlen + 3'd1;
    end else begin
      if (c.wlen == 3'd5 && c.word == "begin") n.depth = c.depth + 16'd1;
      else if (c.wlen == 3'd3 && c.word[23:0] == "end") begin
        if (c.depth == 16'd0) n.bad = 1'b1;
        else n.depth = c.depth - 16'd1;
      end
      n.word = '0;
      n.wlen = '0;
    end
    return n;
  endfunction

  always @(posedge clk) cs_a <= a_crst ? '0 : chk_step(cs_a, a_cin);
  always @(posedge clk) cs_b <= b_crst ? '0 : chk_step(cs_b, b_cin);
  assign a_cres = (cs_a.depth == 16'd0) && !cs_a.bad;
  assign b_cres = (cs_b.depth == 16'd0) && !cs_b.bad;

  // Reference: balanced-ness of a whole message string, trailing space appended.
  function automatic bit ref_balanced(input string s);
    string t, w;
    int depth;
    bit bad;
    logic [7:0] c;
    t = {s.tolower(), " "};
    w = "";
    depth = 0;
    bad = 1'b0;
    for (int i = 0; i < t.len(); i++) begin
      c = t[i];
      if (c >= 8'h61 && c <= 8'h7a) w = {w, t.substr(i, i)};
      else begin
        if (w == "begin") depth++;
        else if (w == "end") begin
          if (depth == 0) bad = 1'b1;
          else depth--;
        end
        w = "";
      end
    end
    return (depth == 0) && !bad;
  endfunction

  typedef struct {
    logic [1:0] vec;
    logic       ok;
    logic       err;
    int         cyc;
  } resp_t;

  resp_t      rqa[$], rqb[$];
  logic [7:0] cin_at [int];
  logic       crst_at [int];

  always @(negedge clk) begin
    resp_t r;
    cin_at[cyc]  = a_cin;
    crst_at[cyc] = a_crst;
    if (|a_rv) begin
      r.vec = a_rv; r.ok = a_ok; r.err = a_err; r.cyc = cyc;
      rqa.push_back(r);
    end
    if (|b_rv) begin
      r.vec = b_rv; r.ok = b_ok; r.err = b_err; r.cyc = cyc;
      rqb.push_back(r);
    end
  end

  task automatic vset(input int dsel, input int r, input logic val,
                      input logic [7:0] ch, input logic lst);
    if (dsel == 0) begin
      a_v[r] = val; a_d[8*r +: 8] = ch; a_l[r] = lst;
    end else begin
      b_v[r] = val; b_d[8*r +: 8] = ch; b_l[r] = lst;
    end
  endtask

  function automatic logic rdy(input int dsel, input int r);
    return (dsel == 0) ? a_rdy[r] : b_rdy[r];
  endfunction

  // Streams s contiguously; bubble_at >= 0 drops valid before that character.
  task automatic drive(input int dsel, input int r, input string s, input int bubble_at);
    int w;
    for (int i = 0; i < s.len(); i++) begin
      if (i == bubble_at) begin
        vset(dsel, r, 1'b0, 8'h00, 1'b0);
        return;
      end
      vset(dsel, r, 1'b1, s[i], (i == s.len() - 1));
      w = 0;
      while (!rdy(dsel, r)) begin
        @(negedge clk);
        w++;
        if (w > 300) begin
          n_chk++; n_err++;
          $display("FAIL ready_timeout: dut%0d req%0d char %0d got no ready in %0d cycles, want ready", dsel, r, i, w);
          vset(dsel, r, 1'b0, 8'h00, 1'b0);
          return;
        end
      end
      if (i == 0) first_acc[dsel][r] = cyc;
      last_acc[dsel][r] = cyc;
      @(negedge clk);
    end
    vset(dsel, r, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_resp(input int dsel, input int r, input logic eok, input logic eerr,
                           input int ecyc, input string nm);
    resp_t x;
    int w;
    w = 0;
    while (((dsel == 0) ? rqa.size() : rqb.size()) == 0 && w < 400) begin
      @(negedge clk); #1; w++;
    end
    n_chk++;
    if (((dsel == 0) ? rqa.size() : rqb.size()) == 0) begin
      n_err++;
      $display("FAIL %s_resp: no response after %0d cycles, want one for req%0d", nm, w, r);
      return;
    end
    if (dsel == 0) x = rqa.pop_front();
    else x = rqb.pop_front();
    n_chk++;
    if (x.vec !== 2'(1 << r)) begin
      n_err++;
      $display("FAIL %s_vec: resp_valid=%b, want %b", nm, x.vec, 2'(1 << r));
    end
    n_chk++;
    if ({x.ok, x.err} !== {eok, eerr}) begin
      n_err++;
      $display("FAIL %s_verdict: ok=%b err=%b, want ok=%b err=%b", nm, x.ok, x.err, eok, eerr);
    end
    n_chk++;
    if (x.cyc != ecyc) begin
      n_err++;
      $display("FAIL %s_time: response at cycle %0d, want %0d", nm, x.cyc, ecyc);
    end
    if (dsel == 0) exp_rr = (r + 1) % 2;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    a_v = '0; a_l = '0; b_v = '0; b_l = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_rr = 0;
    @(negedge clk);
    rqa.delete();
    rqb.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if (a_crst !== 1'b1) begin
      n_err++; $display("FAIL rst_chk_reset_hi: chk_reset=%b, want 1", a_crst);
    end
    reset = 1'b0;
    #1;
    n_chk++;
    if ({a_rdy, a_rv, a_ok, a_err, a_busy, a_gi} !== 8'b0) begin
      n_err++;
      $display("FAIL rst_outputs: ready=%b resp_valid=%b ok=%b err=%b busy=%b grant=%b, want all 0",
               a_rdy, a_rv, a_ok, a_err, a_busy, a_gi);
    end
    n_chk++;
    if (a_cin !== 8'h20) begin
      n_err++; $display("FAIL rst_chk_in: chk_in=%h, want 20", a_cin);
    end
    n_chk++;
    if (a_crst !== 1'b0) begin
      n_err++; $display("FAIL rst_chk_reset_lo: chk_reset=%b in idle, want 0", a_crst);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    string s;
    int f;
    logic [7:0] ch;
    s = "begin end";
    drive(0, 0, s, -1);
    wait_resp(0, 0, 1'b1, 1'b0, last_acc[0][0] + 2, "single");
    f = first_acc[0][0];
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      n_chk++;
      if (cin_at[f + i] !== ch) begin
        n_err++; $display("FAIL single_chk_in%0d: chk_in=%h, want %h", i, cin_at[f + i], ch);
      end
    end
    n_chk++;
    if (cin_at[f + s.len()] !== 8'h20) begin
      n_err++; $display("FAIL single_tail: chk_in=%h in tail, want 20", cin_at[f + s.len()]);
    end
    n_chk++;
    if ({crst_at[f - 1], cin_at[f - 1]} !== {1'b1, 8'h20}) begin
      n_err++;
      $display("FAIL single_flush: chk_reset=%b chk_in=%h, want 1 20", crst_at[f - 1], cin_at[f - 1]);
    end
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    fork
      drive(0, 0, "begin", -1);
      drive(0, 1, "end", -1);
    join
    wait_resp(0, 0, 1'b0, 1'b0, last_acc[0][0] + 2, "simul_r0");
    wait_resp(0, 1, 1'b0, 1'b0, last_acc[0][1] + 2, "simul_r1");
    n_chk++;
    if (first_acc[0][1] != last_acc[0][0] + 5) begin
      n_err++;
      $display("FAIL simul_grant_gap: req1 first char at %0d, want %0d", first_acc[0][1], last_acc[0][0] + 5);
    end
    n_chk++;
    if (a_gi !== 1'b1) begin
      n_err++; $display("FAIL simul_grant_idx: grant_idx=%b, want 1", a_gi);
    end
    @(negedge clk);
    fork
      drive(0, 0, "begin end", -1);
      drive(0, 1, "x", -1);
    join
    wait_resp(0, 0, 1'b1, 1'b0, last_acc[0][0] + 2, "rr_back_r0");
    wait_resp(0, 1, 1'b1, 1'b0, last_acc[0][1] + 2, "rr_back_r1");
    @(negedge clk);
  endtask

  task automatic test_case_fold();
    drive(0, 1, "BEGIN endx END", -1);
    wait_resp(0, 1, 1'b1, 1'b0, last_acc[0][1] + 2, "casefold");
    @(negedge clk);
  endtask

  task automatic test_bubble();
    drive(0, 0, "begin end", 3);
    wait_resp(0, 0, 1'b0, 1'b1, last_acc[0][0] + 3, "bubble");
    @(negedge clk);
    drive(0, 0, "begin end", -1);
    wait_resp(0, 0, 1'b1, 1'b0, last_acc[0][0] + 2, "after_bubble");
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int acc, w;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      vset(1, 0, 1'b1, 8'h61 + 8'(i), 1'b0);
      w = 0;
      while (!b_rdy[0] && w < 20) begin
        @(negedge clk); w++;
      end
      if (b_rdy[0]) acc++;
      @(negedge clk);
    end
    n_chk++;
    if (acc != 8) begin
      n_err++; $display("FAIL ovf_accepted: %0d characters accepted, want 8", acc);
    end
    vset(1, 0, 1'b1, 8'h69, 1'b0);
    n_chk++;
    if (b_rdy !== 2'b00) begin
      n_err++; $display("FAIL ovf_ninth_ready: req_ready=%b for 9th char, want 00", b_rdy);
    end
    @(negedge clk);
    n_chk++;
    if (b_rv !== 2'b01) begin
      n_err++; $display("FAIL ovf_resp_valid: resp_valid=%b, want 01", b_rv);
    end
    n_chk++;
    if ({b_ok, b_err} !== 2'b01) begin
      n_err++; $display("FAIL ovf_verdict: ok=%b err=%b, want ok=0 err=1", b_ok, b_err);
    end
    vset(1, 0, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rqb.delete();
    drive(1, 0, "ab cd ef", -1);
    wait_resp(1, 0, 1'b1, 1'b0, last_acc[1][0] + 2, "fit8");
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int w;
    vset(0, 0, 1'b1, 8'h62, 1'b0);
    w = 0;
    while (!a_rdy[0] && w < 20) begin
      @(negedge clk); w++;
    end
    @(negedge clk);
    vset(0, 0, 1'b1, 8'h65, 1'b0);
    @(negedge clk);
    n_chk++;
    if (a_busy !== 1'b1) begin
      n_err++; $display("FAIL mid_busy_before: busy=%b mid-message, want 1", a_busy);
    end
    reset = 1'b1;
    a_v = '0; a_l = '0;
    @(negedge clk);
    n_chk++;
    if ({a_busy, a_crst, a_rdy} !== 4'b0100) begin
      n_err++;
      $display("FAIL mid_reset: busy=%b chk_reset=%b ready=%b, want 0 1 00", a_busy, a_crst, a_rdy);
    end
    reset = 1'b0;
    exp_rr = 0;
    repeat (6) @(negedge clk);
    #1;
    n_chk++;
    if (rqa.size() != 0) begin
      n_err++; $display("FAIL mid_no_resp: %0d responses after abort, want 0", rqa.size());
    end
    rqa.delete();
    drive(0, 0, "begin end", -1);
    wait_resp(0, 0, 1'b1, 1'b0, last_acc[0][0] + 2, "mid_after");
    @(negedge clk);
  endtask

  function automatic string rand_msg();
    string words[8];
    string s;
    int n;
    words = '{"begin", "end", "BEGIN", "End", "x", "ends", "beginx", "Begin"};
    n = $urandom_range(1, 5);
    s = "";
    for (int i = 0; i < n; i++) begin
      s = {s, words[$urandom_range(0, 7)]};
      if (i != n - 1) s = {s, ($urandom_range(0, 2) == 0) ? "," : " "};
    end
    return s;
  endfunction

  task automatic test_random();
    string s [2];
    int mode, r, win, lose, bub;
    for (int it = 0; it < 24; it++) begin
      mode = $urandom_range(0, 2);
      if (mode == 2) begin
        s[0] = rand_msg();
        s[1] = rand_msg();
        win  = exp_rr;
        lose = 1 - win;
        fork
          drive(0, 0, s[0], -1);
          drive(0, 1, s[1], -1);
        join
        wait_resp(0, win, ref_balanced(s[win]), 1'b0, last_acc[0][win] + 2, "rand_win");
        wait_resp(0, lose, ref_balanced(s[lose]), 1'b0, last_acc[0][lose] + 2, "rand_lose");
        n_chk++;
        if (first_acc[0][lose] != last_acc[0][win] + 5) begin
          n_err++;
          $display("FAIL rand_gap: loser first char at %0d, want %0d", first_acc[0][lose], last_acc[0][win] + 5);
        end
      end else begin
        r    = $urandom_range(0, 1);
        s[0] = rand_msg();
        bub  = (mode == 1 && s[0].len() > 1) ? $urandom_range(1, s[0].len() - 1) : -1;
        drive(0, r, s[0], bub);
        if (bub >= 0) wait_resp(0, r, 1'b0, 1'b1, last_acc[0][r] + 3, "rand_bubble");
        else wait_resp(0, r, ref_balanced(s[0]), 1'b0, last_acc[0][r] + 2, "rand_single");
      end
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_case_fold();
    test_bubble();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
